// File: rtl/array_index_pkg.sv
// Shared types and helpers for the sequential array index search engine.
package array_index_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        FINISH
    } state_t;

    localparam int unsigned NOT_FOUND = 0;

    // Effective search length: elements beyond the array area are never read.
    function automatic int unsigned clamp_size(input int unsigned size, input int unsigned limit);
        return (size < limit) ? size : limit;
    endfunction

endpackage

// File: rtl/array_index_search.sv
// Sequential replacement for the combinational arrayIndex loop: scans one heap element per cycle.
// Optional ARRAY_INDEX_EARLY_EXIT_EN: descending scan that stops at the first match.
module array_index_search
    import array_index_pkg::*;
#(
    parameter int MemoryElementWidth = 12,
    parameter int NArea              = 4,
    parameter int NHeap              = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [MemoryElementWidth-1:0] array,
    input  logic [MemoryElementWidth-1:0] size,
    input  logic [MemoryElementWidth-1:0] key,
    output logic                          busy,
    output logic                          done,
    output logic [MemoryElementWidth-1:0] index,
    output logic                          heapRead,
    output logic [NHeap-1:0]              heapAddress,
    input  logic [MemoryElementWidth-1:0] heapOut
);

    localparam int CntW = $clog2(NArea + 1);
    localparam int MW   = MemoryElementWidth;

    state_t          r_state;
    state_t          w_next;
    logic [CntW-1:0] r_k;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] r_rd_elem;
    logic [CntW-1:0] w_elem;
    logic [CntW-1:0] w_k_in;
    logic [NHeap-1:0] r_base;
    logic [MW-1:0]   r_key;
    logic [MW-1:0]   r_match;
    logic [MW-1:0]   r_index;
    logic [MW-1:0]   w_result;
    logic            r_rd_valid;
    logic            w_hit;
    logic            w_accept;

    assign w_k_in   = CntW'(clamp_size(32'(size), NArea));
    assign w_accept = start && (r_state == IDLE);

`ifdef ARRAY_INDEX_EARLY_EXIT_EN
    assign w_elem = r_k - CntW'(1) - r_cnt;
`else
    assign w_elem = r_cnt;
`endif

    // Read data lags the strobe by one cycle; r_rd_elem tags which element it belongs to.
    assign w_hit    = r_rd_valid && (heapOut == r_key);
    assign w_result = w_hit ? (MW'(r_rd_elem) + MW'(1)) : r_match;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (w_k_in == '0) ? FINISH : SCAN;
                end
            end
            SCAN: begin
`ifdef ARRAY_INDEX_EARLY_EXIT_EN
                if (w_hit) begin
                    w_next = FINISH;
                end else
`endif
                if (r_cnt == r_k - CntW'(1)) begin
                    w_next = DRAIN;
                end
            end
            DRAIN:   w_next = FINISH;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_k        <= '0;
            r_cnt      <= '0;
            r_rd_elem  <= '0;
            r_rd_valid <= 1'b0;
            r_base     <= '0;
            r_key      <= '0;
            r_match    <= MW'(NOT_FOUND);
            r_index    <= MW'(NOT_FOUND);
        end else begin
            r_state    <= w_next;
            r_rd_valid <= (r_state == SCAN);
            r_rd_elem  <= w_elem;
            if (w_accept) begin
                r_key   <= key;
                r_base  <= NHeap'(array * NArea);
                r_k     <= w_k_in;
                r_cnt   <= '0;
                r_match <= MW'(NOT_FOUND);
                if (w_k_in == '0) begin
                    r_index <= MW'(NOT_FOUND);
                end
            end
            if (r_state == SCAN) begin
                r_cnt <= r_cnt + CntW'(1);
            end
            // Result is published only when the search completes, so index holds the previous answer meanwhile.
            if ((r_state == SCAN) || (r_state == DRAIN)) begin
                r_match <= w_result;
                if (w_next == FINISH) begin
                    r_index <= w_result;
                end
            end
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = (r_state == FINISH);
    assign index       = r_index;
    assign heapRead    = (r_state == SCAN);
    assign heapAddress = heapRead ? (r_base + NHeap'(w_elem)) : '0;

endmodule

// File: tb/tb_array_index_search.sv
// Self-checking bench for array_index_search with a 1-cycle synchronous heap model and a scoreboard.
// Define ARRAY_INDEX_EARLY_EXIT_EN for both bench and RTL to check the early-exit build.
module tb_array_index_search;

    logic        clock;
    logic        reset;
    logic        start;
    logic [11:0] array;
    logic [11:0] size;
    logic [11:0] key;
    logic        busy;
    logic        done;
    logic [11:0] index;
    logic        heapRead;
    logic [3:0]  heapAddress;
    logic [11:0] heapOut;

    logic [11:0] heap [16];
    logic [11:0] exp_q [$];
    int          lat_q [$];
    int          n_checks;
    int          n_errors;

    array_index_search dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .array       (array),
        .size        (size),
        .key         (key),
        .busy        (busy),
        .done        (done),
        .index       (index),
        .heapRead    (heapRead),
        .heapAddress (heapAddress),
        .heapOut     (heapOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (heapRead) heapOut <= heap[heapAddress];
    end

    // Reference behaviour: expected index and done cycle (start sampled in cycle 0).
    function automatic void model(input logic [11:0] arr, input logic [11:0] sz, input logic [11:0] ky,
                                  output logic [11:0] idx, output int lat);
        int k;
        int base;
        k    = (sz < 12'd4) ? int'(sz) : 4;
        base = int'(arr) * 4;
        idx  = 12'd0;
        lat  = (k == 0) ? 1 : k + 2;
`ifdef ARRAY_INDEX_EARLY_EXIT_EN
        for (int m = 0; m < k; m++) begin
            if (heap[(base + k - 1 - m) & 15] == ky) begin
                idx = 12'(k - m);
                lat = m + 3;
                break;
            end
        end
`else
        for (int i = 0; i < k; i++) begin
            if (heap[(base + i) & 15] == ky) idx = 12'(i + 1);
        end
`endif
    endfunction

    // Caller is aligned to a negedge; returns at the negedge after done.
    task automatic run_search(input logic [11:0] arr, input logic [11:0] sz, input logic [11:0] ky,
                              input int busy_poke, input string name);
        logic [11:0] e_idx;
        logic [11:0] got_idx;
        int          e_lat;
        int          got_lat;
        int          k;
        int          off;
        bit          seen;
        bit          bad_read;
        bit          busy_ok;
        model(arr, sz, ky, e_idx, e_lat);
        exp_q.push_back(e_idx);
        lat_q.push_back(e_lat);
        k        = (sz < 12'd4) ? int'(sz) : 4;
        seen     = 1'b0;
        bad_read = 1'b0;
        busy_ok  = 1'b1;
        got_lat  = 0;
        got_idx  = '0;
        array = arr; size = sz; key = ky; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == busy_poke) begin
                start = 1'b1; key = ky + 12'd1; array = arr + 12'd1; size = 12'd4;
            end else begin
                start = 1'b0;
            end
            if (c == 1 && !busy) busy_ok = 1'b0;
            if (heapRead) begin
                off = (int'(heapAddress) - int'(arr) * 4) & 15;
                if (off >= k) bad_read = 1'b1;
            end
            if (done) begin
                seen = 1'b1; got_lat = c; got_idx = index;
                break;
            end
            @(negedge clock);
        end
        start = 1'b0;
        e_idx = exp_q.pop_front();
        e_lat = lat_q.pop_front();
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL %s_timeout: done not seen within 20 cycles, required cycle %0d", name, e_lat);
        end else begin
            n_checks++;
            if (got_idx !== e_idx) begin
                n_errors++;
                $display("FAIL %s_index: got %0d, expected %0d", name, got_idx, e_idx);
            end
            if (got_lat !== e_lat) begin
                n_errors++;
                $display("FAIL %s_latency: done in cycle %0d, expected cycle %0d", name, got_lat, e_lat);
            end
        end
        n_checks++;
        if (bad_read) begin
            n_errors++;
            $display("FAIL %s_reads: heap read outside elements 0..%0d, expected none", name, k - 1);
        end
        n_checks++;
        if (!busy_ok) begin
            n_errors++;
            $display("FAIL %s_busy: busy 0 in cycle 1, expected 1", name);
        end
        @(negedge clock);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_after_done: done=%0b busy=%0b, expected 0 0", name, done, busy);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || heapRead !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_ctrl: busy=%0b done=%0b heapRead=%0b, expected 0 0 0", name, busy, done, heapRead);
        end
        n_checks++;
        if (index !== 12'd0) begin
            n_errors++;
            $display("FAIL %s_index: got %0d, expected 0", name, index);
        end
        n_checks++;
        if (heapAddress !== 4'd0) begin
            n_errors++;
            $display("FAIL %s_addr: got %0d, expected 0", name, heapAddress);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; array = '0; size = '0; key = '0;
        for (int i = 0; i < 16; i++) heap[i] = 12'd0;
        heap[0] = 12'd10; heap[1] = 12'd20; heap[2]  = 12'd30;
        heap[4] = 12'd20; heap[5] = 12'd20; heap[6]  = 12'd30; heap[7]  = 12'd20;
        heap[8] = 12'd1;  heap[9] = 12'd2;  heap[10] = 12'd3;  heap[11] = 12'd77;
        repeat (2) @(negedge clock);
        check_outputs_zero("reset");
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        run_search(12'd0, 12'd3, 12'd20, 0, "hit_mid");
        run_search(12'd0, 12'd3, 12'd99, 0, "miss");
    endtask

    task automatic test_size_limits();
        run_search(12'd1, 12'd3, 12'd20, 0, "beyond_size");
        run_search(12'd0, 12'd0, 12'd10, 0, "size_zero");
        run_search(12'd2, 12'd7, 12'd77, 0, "size_clamp");
    endtask

    task automatic test_busy_ignore();
        run_search(12'd0, 12'd3, 12'd20, 2, "start_while_busy");
    endtask

    task automatic test_reset_mid_scan();
        bit seen_done;
        array = 12'd0; size = 12'd3; key = 12'd20; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        seen_done = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (done) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done) begin
            n_errors++;
            $display("FAIL mid_reset_done: done pulsed during reset, expected none");
        end
        reset = 1'b1;
        run_search(12'd0, 12'd3, 12'd20, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        run_search(12'd1, 12'd4, 12'd20, 0, "b2b_full");
        run_search(12'd5, 12'd2, 12'd20, 0, "b2b_wrap");
        run_search(12'd0, 12'd1, 12'd10, 0, "b2b_one");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) heap[i] = 12'($urandom_range(0, 3));
        for (int n = 0; n < 24; n++) begin
            run_search(12'($urandom_range(0, 7)), 12'($urandom_range(0, 6)),
                       12'($urandom_range(0, 4)), 0, "random");
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_basic();
        test_size_limits();
        test_busy_ignore();
        test_reset_mid_scan();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/array_index_search.md
# array_index_search

Sequential search engine that replaces the combinational `arrayIndex` loop in the test-program sequencer. Given an array number, a length and a key, it reads the array's heap area one element per cycle through a single synchronous-read heap port, and returns the 1-based position of the last matching element, or 0 when there is no match. It sits between the instruction sequencer, which issues a start and then waits for done, and the heap memory.

## Interface
- `MemoryElementWidth`, 12: data, key, size and result width.
- `NArea`, 4: elements per array area on the heap.
- `NHeap`, 4: heap address width.
- `clock` in 1: the block's only clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request a search. Sampled only while `busy` = 0.
- `array` in MemoryElementWidth: array number. Base address = `array*NArea`.
- `size` in MemoryElementWidth: current array length.
- `key` in MemoryElementWidth: value to search for.
- `busy` out 1: high from the cycle after an accepted start until `done`.
- `done` out 1: one-cycle pulse; `index` is valid in this cycle.
- `index` out MemoryElementWidth: 1-based match position, 0 = not found. Held until the next accepted start.
- `heapRead` out 1: read strobe.
- `heapAddress` out NHeap: read address.
- `heapOut` in MemoryElementWidth: read data, valid the cycle after `heapRead`.

## Operation
- Reset values: `busy`=0, `done`=0, `index`=0, `heapRead`=0, `heapAddress`=0.
- State machine:
  - IDLE: accepted start goes to SCAN, or to FINISH when the effective size is 0.
  - SCAN: one read issued per cycle.
  - DRAIN: final compare.
  - FINISH: pulse `done`, return to IDLE.
- Effective size is `k = min(size, NArea)`. Elements at index ≥ NArea are never read.
- Element address is `(array*NArea + i)` truncated to NHeap bits (wraps modulo 2^NHeap).
- Inputs `array`, `size` and `key` are captured at start. Later changes to them have no effect on the running search.
- Compare is full-width equality of `heapOut` against the captured key.
- Result rule: `index = i+1` for the highest i < k with a match, else 0. Duplicate matches report the last one.
- Start while `busy` = 1 is ignored.
- Reset asserted mid-search aborts at once: all outputs go to reset values and no `done` is produced.
- `heapRead` is never asserted outside SCAN.

## Timing
- Start is sampled in cycle 0.
- Size 0: `done` in cycle 1, no heap reads.
- Default (ascending scan):
  - element j is read in cycle j+1, and its data arrives in cycle j+2;
  - `done` is high in cycle k+2 for every k ≥ 1.
- The next start can be accepted in the cycle after `done`.

## Configuration
- `ARRAY_INDEX_EARLY_EXIT_EN` defined:
  - the scan runs in descending order: the m-th read (m = 0..k-1) is element k-1-m, issued in cycle m+1;
  - the first match ends the search, with `done` in cycle m+3;
  - reads already in flight are discarded;
  - with no match, `done` is in cycle k+2.
  - The result is identical to the default mode; only the latency differs.
- Not defined: ascending full scan with fixed latency k+2.

## Structure
- Shared package `array_index_pkg` holds:
  - the state enum (IDLE, SCAN, DRAIN, FINISH);
  - the localparam for the not-found value (0);
  - a `clamp_size` function.
- No sub-module. The counter, the compare register and the FSM sit in one module.
- The bench provides a synchronous-read heap model with 1-cycle latency.

## Test plan
- Array 0 = {10,20,30}, size 3, key 20:
  - default mode: `index`=2, `done` in cycle 5;
  - with EARLY_EXIT: `done` in cycle 4.
- Array 1 = {20,20,30,20}, size 3, key 20 → `index`=2 (the element at i=3 lies beyond size and is ignored).
- Array 0 = {10,20,30}, size 3, key 99 → `index`=0, `done` in cycle 5 in both modes.
- Size 0 → `index`=0, `done` in cycle 1, `heapRead` never high. Size 7 with key at element 3 → `index`=4, and no address above `array*4+3` is read.
- Start while busy with a different key → ignored; the first search's result is reported.
- Reset pulled low in cycle 2 of a scan → all outputs are 0 immediately and no `done` appears. After release, a new search returns the correct result.
